// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the IF/MEM SRAM arbiter: response owner encoding
// and default bus widths.
package sram_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  // Which requester a returning read word belongs to.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the SRAM macro port.
// The slave modport is the arbiter's view; the master modport is the view of
// the surrounding pipeline stages and SRAM macro.
interface sram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_cancel;
  logic              inst_ready;
  logic              inst_rvalid;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic [BE_W-1:0]   data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ready;
  logic              data_rvalid;
  logic [DATA_W-1:0] data_rdata;

  logic              sram_en;
  logic [BE_W-1:0]   sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport slave (
    input  inst_req, inst_addr, inst_cancel,
    output inst_ready, inst_rvalid, inst_rdata,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_ready, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output inst_req, inst_addr, inst_cancel,
    input  inst_ready, inst_rvalid, inst_rdata,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_ready, data_rvalid, data_rdata,
    input  sram_en, sram_wen, sram_addr, sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/sram_arbiter.sv
// Fixed-priority arbiter sharing one single-port synchronous-read SRAM between
// instruction fetch and load/store. Data accesses win unless the fetch has
// been denied STARVE_MAX cycles in a row; read data returns one cycle after
// the grant and is steered to whichever requester owned that grant.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic           clk,
  input  logic           reset,
  sram_arbiter_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             inst_grant;
  logic             data_grant;
  logic             rd_grant;

  // Response pipeline: one slot, aligned with the SRAM read latency.
  logic             resp_vld_p1;
  owner_e           resp_own_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Grant decision: data first, unless the fetch has waited long enough.
  always_comb begin
    starved    = (starve_cnt == CNT_MAX);
    inst_grant = bus.inst_req & (~bus.data_req | starved);
    data_grant = bus.data_req & ~inst_grant;
    rd_grant   = inst_grant | (data_grant & (bus.data_wen == '0));
  end

  assign bus.inst_ready = inst_grant;
  assign bus.data_ready = data_grant;

  // SRAM port mux; the bus is fully quiet when nobody is granted.
  always_comb begin
    bus.sram_en    = 1'b0;
    bus.sram_wen   = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    if (data_grant) begin
      bus.sram_en    = 1'b1;
      bus.sram_wen   = bus.data_wen;
      bus.sram_addr  = bus.data_addr;
      bus.sram_wdata = bus.data_wdata;
    end else if (inst_grant) begin
      bus.sram_en    = 1'b1;
      bus.sram_addr  = bus.inst_addr;
    end
  end

  // Count consecutive cycles a pending fetch is refused; any grant or idle clears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (bus.inst_req & ~inst_grant) begin
      starve_cnt <= sat_inc(starve_cnt);
    end else begin
      starve_cnt <= '0;
    end
  end

  // Remember whether this cycle's grant produces a read word, and for whom.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_vld_p1 <= 1'b0;
      resp_own_p1 <= OWN_INST;
    end else begin
      resp_vld_p1 <= rd_grant;
      resp_own_p1 <= inst_grant ? OWN_INST : OWN_DATA;
    end
  end

  // A branch flush only suppresses the fetch word arriving this cycle.
  assign bus.inst_rvalid = resp_vld_p1 & (resp_own_p1 == OWN_INST) & ~bus.inst_cancel;
  assign bus.data_rvalid = resp_vld_p1 & (resp_own_p1 == OWN_DATA);
  assign bus.inst_rdata  = bus.sram_rdata;
  assign bus.data_rdata  = bus.sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by randomized traffic
// against a cycle-level reference model of the arbitration rules.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = DATA_W / 8;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Content of the SRAM as seen by reads: a fixed scramble of the address.
  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // SRAM macro model: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (bus.sram_en && bus.sram_wen == '0) bus.sram_rdata <= mem_val(bus.sram_addr);
  end

  task automatic idle_inputs();
    bus.inst_req    = 1'b0;
    bus.inst_addr   = '0;
    bus.inst_cancel = 1'b0;
    bus.data_req    = 1'b0;
    bus.data_wen    = '0;
    bus.data_addr   = '0;
    bus.data_wdata  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.inst_ready !== 1'b0) begin n_fail++; $display("FAIL rst_inst_ready got %b want 0", bus.inst_ready); end
    n_checks++; if (bus.data_ready !== 1'b0) begin n_fail++; $display("FAIL rst_data_ready got %b want 0", bus.data_ready); end
    n_checks++; if (bus.inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_inst_rvalid got %b want 0", bus.inst_rvalid); end
    n_checks++; if (bus.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_data_rvalid got %b want 0", bus.data_rvalid); end
    n_checks++; if (bus.sram_en !== 1'b0) begin n_fail++; $display("FAIL rst_sram_en got %b want 0", bus.sram_en); end
    n_checks++; if (bus.sram_wen !== 4'h0) begin n_fail++; $display("FAIL rst_sram_wen got %h want 0", bus.sram_wen); end
    n_checks++; if (bus.sram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_sram_addr got %h want 0", bus.sram_addr); end
    n_checks++; if (bus.sram_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_sram_wdata got %h want 0", bus.sram_wdata); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fetch_only();
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0000;
    @(negedge clk);
    n_checks++; if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL fetch_ready got %b want 1", bus.inst_ready); end
    n_checks++; if (bus.sram_en !== 1'b1) begin n_fail++; $display("FAIL fetch_sram_en got %b want 1", bus.sram_en); end
    n_checks++; if (bus.sram_addr !== 32'h1C00_0000) begin n_fail++; $display("FAIL fetch_sram_addr got %h want 1c000000", bus.sram_addr); end
    n_checks++; if (bus.sram_wen !== 4'h0) begin n_fail++; $display("FAIL fetch_sram_wen got %h want 0", bus.sram_wen); end
    n_checks++; if (bus.inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_rvalid got %b want 0", bus.inst_rvalid); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.inst_rvalid !== 1'b1) begin n_fail++; $display("FAIL fetch_rvalid got %b want 1", bus.inst_rvalid); end
    n_checks++; if (bus.inst_rdata !== mem_val(32'h1C00_0000)) begin n_fail++; $display("FAIL fetch_rdata got %h want %h", bus.inst_rdata, mem_val(32'h1C00_0000)); end
    n_checks++; if (bus.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL fetch_data_rvalid got %b want 0", bus.data_rvalid); end
  endtask

  task automatic test_contention();
    logic [ADDR_W-1:0] prev_addr;
    bit                prev_inst;
    prev_addr = '0;
    prev_inst = 1'b0;
    tick();
    idle_inputs();
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h0000_2000;
      bus.data_req  = 1'b1;
      bus.data_wen  = '0;
      bus.data_addr = 32'h0000_0300 + 32'(c * 4);
      @(negedge clk);
      n_checks++; if (bus.inst_ready !== (c == 5)) begin n_fail++; $display("FAIL cont_inst_ready c=%0d got %b want %b", c, bus.inst_ready, (c == 5)); end
      n_checks++; if (bus.data_ready !== (c != 5)) begin n_fail++; $display("FAIL cont_data_ready c=%0d got %b want %b", c, bus.data_ready, (c != 5)); end
      if (c >= 2) begin
        n_checks++; if (bus.inst_rvalid !== prev_inst) begin n_fail++; $display("FAIL cont_inst_rvalid c=%0d got %b want %b", c, bus.inst_rvalid, prev_inst); end
        n_checks++; if (bus.data_rvalid !== !prev_inst) begin n_fail++; $display("FAIL cont_data_rvalid c=%0d got %b want %b", c, bus.data_rvalid, !prev_inst); end
        if (!prev_inst) begin
          n_checks++; if (bus.data_rdata !== mem_val(prev_addr)) begin n_fail++; $display("FAIL cont_data_rdata c=%0d got %h want %h", c, bus.data_rdata, mem_val(prev_addr)); end
        end
      end
      prev_inst = (c == 5);
      prev_addr = (c == 5) ? 32'h0000_2000 : bus.data_addr;
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.data_rvalid !== 1'b1) begin n_fail++; $display("FAIL cont_last_rvalid got %b want 1", bus.data_rvalid); end
    n_checks++; if (bus.data_rdata !== mem_val(prev_addr)) begin n_fail++; $display("FAIL cont_last_rdata got %h want %h", bus.data_rdata, mem_val(prev_addr)); end
  endtask

  task automatic test_store();
    tick();
    bus.data_req   = 1'b1;
    bus.data_wen   = 4'b0011;
    bus.data_wdata = 32'hDEAD_BEEF;
    bus.data_addr  = 32'h0000_0100;
    @(negedge clk);
    n_checks++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL store_ready got %b want 1", bus.data_ready); end
    n_checks++; if (bus.sram_wen !== 4'b0011) begin n_fail++; $display("FAIL store_sram_wen got %b want 0011", bus.sram_wen); end
    n_checks++; if (bus.sram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_sram_wdata got %h want deadbeef", bus.sram_wdata); end
    n_checks++; if (bus.sram_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL store_sram_addr got %h want 100", bus.sram_addr); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL store_rvalid got %b want 0", bus.data_rvalid); end
    n_checks++; if (bus.sram_wen !== 4'h0) begin n_fail++; $display("FAIL store_wen_after got %b want 0", bus.sram_wen); end
    n_checks++; if (bus.sram_en !== 1'b0) begin n_fail++; $display("FAIL store_en_after got %b want 0", bus.sram_en); end
  endtask

  task automatic test_flush();
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0040;
    @(negedge clk);
    n_checks++; if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL flush_first_ready got %b want 1", bus.inst_ready); end
    tick();
    bus.inst_addr   = 32'h1C00_0080;
    bus.inst_cancel = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL flush_masked_rvalid got %b want 0", bus.inst_rvalid); end
    n_checks++; if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL flush_new_ready got %b want 1", bus.inst_ready); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.inst_rvalid !== 1'b1) begin n_fail++; $display("FAIL flush_new_rvalid got %b want 1", bus.inst_rvalid); end
    n_checks++; if (bus.inst_rdata !== mem_val(32'h1C00_0080)) begin n_fail++; $display("FAIL flush_new_rdata got %h want %h", bus.inst_rdata, mem_val(32'h1C00_0080)); end
  endtask

  task automatic test_interleave();
    tick();
    bus.inst_req  = 1'b1;
    bus.inst_addr = 32'h1C00_0100;
    @(negedge clk);
    n_checks++; if (bus.inst_ready !== 1'b1) begin n_fail++; $display("FAIL ilv_inst_ready got %b want 1", bus.inst_ready); end
    tick();
    idle_inputs();
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0000_0440;
    @(negedge clk);
    n_checks++; if (bus.data_ready !== 1'b1) begin n_fail++; $display("FAIL ilv_data_ready got %b want 1", bus.data_ready); end
    n_checks++; if (bus.inst_rvalid !== 1'b1) begin n_fail++; $display("FAIL ilv_inst_rvalid got %b want 1", bus.inst_rvalid); end
    n_checks++; if (bus.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL ilv_data_rvalid_n1 got %b want 0", bus.data_rvalid); end
    n_checks++; if (bus.inst_rdata !== mem_val(32'h1C00_0100)) begin n_fail++; $display("FAIL ilv_inst_rdata got %h want %h", bus.inst_rdata, mem_val(32'h1C00_0100)); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.data_rvalid !== 1'b1) begin n_fail++; $display("FAIL ilv_data_rvalid got %b want 1", bus.data_rvalid); end
    n_checks++; if (bus.inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL ilv_inst_rvalid_n2 got %b want 0", bus.inst_rvalid); end
    n_checks++; if (bus.data_rdata !== mem_val(32'h0000_0440)) begin n_fail++; $display("FAIL ilv_data_rdata got %h want %h", bus.data_rdata, mem_val(32'h0000_0440)); end
  endtask

  // Build up fetch starvation, then reset with a read in flight: the read
  // must vanish and the fetch must again wait the full STARVE_MAX cycles.
  task automatic test_reset_mid();
    tick();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      tick();
      bus.inst_req  = 1'b1;
      bus.inst_addr = 32'h0000_5000;
      bus.data_req  = 1'b1;
      bus.data_addr = 32'h0000_0600 + 32'(c * 4);
    end
    @(posedge clk);
    #1;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (bus.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_data_rvalid_in_reset got %b want 0", bus.data_rvalid); end
    n_checks++; if (bus.inst_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_inst_rvalid_in_reset got %b want 0", bus.inst_rvalid); end
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.data_rvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_data_rvalid_after got %b want 0", bus.data_rvalid); end
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        tick();
        bus.data_addr = 32'h0000_0700 + 32'(c * 4);
        @(negedge clk);
      end
      n_checks++; if (bus.inst_ready !== (c == 5)) begin n_fail++; $display("FAIL rmid_inst_ready c=%0d got %b want %b", c, bus.inst_ready, (c == 5)); end
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    int                denied;
    bit                prev_rd;
    owner_e            prev_own;
    logic [ADDR_W-1:0] prev_addr;
    bit                i_pend, d_pend, exp_ir, exp_dr, exp_irv, exp_drv;
    logic [ADDR_W-1:0] i_addr, d_addr, exp_addr;
    logic [BE_W-1:0]   d_wen, exp_wen;
    logic [DATA_W-1:0] d_wdata, exp_wdata;
    denied = 0; prev_rd = 0; prev_own = OWN_INST; prev_addr = '0;
    i_pend = 0; d_pend = 0; i_addr = '0; d_addr = '0; d_wen = '0; d_wdata = '0;
    tick();
    idle_inputs();
    for (int n = 0; n < 600; n++) begin
      tick();
      if (!i_pend && $urandom_range(0, 99) < 60) begin
        i_pend = 1; i_addr = {$urandom} & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 99) < 60) begin
        d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
        d_wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
      bus.inst_req    = i_pend;
      bus.inst_addr   = i_pend ? i_addr : '0;
      bus.inst_cancel = ($urandom_range(0, 99) < 15);
      bus.data_req    = d_pend;
      bus.data_addr   = d_pend ? d_addr : '0;
      bus.data_wen    = d_pend ? d_wen : '0;
      bus.data_wdata  = d_pend ? d_wdata : '0;
      @(negedge clk);
      exp_ir = i_pend && (!d_pend || denied >= STARVE_MAX);
      exp_dr = d_pend && !exp_ir;
      exp_addr  = exp_dr ? d_addr : (exp_ir ? i_addr : '0);
      exp_wen   = exp_dr ? d_wen : '0;
      exp_wdata = exp_dr ? d_wdata : '0;
      exp_irv = prev_rd && prev_own == OWN_INST && !bus.inst_cancel;
      exp_drv = prev_rd && prev_own == OWN_DATA;
      n_checks++; if (bus.inst_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_inst_ready n=%0d got %b want %b", n, bus.inst_ready, exp_ir); end
      n_checks++; if (bus.data_ready !== exp_dr) begin n_fail++; $display("FAIL rnd_data_ready n=%0d got %b want %b", n, bus.data_ready, exp_dr); end
      n_checks++; if (bus.sram_en !== (exp_ir || exp_dr)) begin n_fail++; $display("FAIL rnd_sram_en n=%0d got %b want %b", n, bus.sram_en, (exp_ir || exp_dr)); end
      n_checks++; if (bus.sram_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_sram_addr n=%0d got %h want %h", n, bus.sram_addr, exp_addr); end
      n_checks++; if (bus.sram_wen !== exp_wen) begin n_fail++; $display("FAIL rnd_sram_wen n=%0d got %h want %h", n, bus.sram_wen, exp_wen); end
      n_checks++; if (bus.sram_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_sram_wdata n=%0d got %h want %h", n, bus.sram_wdata, exp_wdata); end
      n_checks++; if (bus.inst_rvalid !== exp_irv) begin n_fail++; $display("FAIL rnd_inst_rvalid n=%0d got %b want %b", n, bus.inst_rvalid, exp_irv); end
      n_checks++; if (bus.data_rvalid !== exp_drv) begin n_fail++; $display("FAIL rnd_data_rvalid n=%0d got %b want %b", n, bus.data_rvalid, exp_drv); end
      if (exp_irv) begin
        n_checks++; if (bus.inst_rdata !== mem_val(prev_addr)) begin n_fail++; $display("FAIL rnd_inst_rdata n=%0d got %h want %h", n, bus.inst_rdata, mem_val(prev_addr)); end
      end
      if (exp_drv) begin
        n_checks++; if (bus.data_rdata !== mem_val(prev_addr)) begin n_fail++; $display("FAIL rnd_data_rdata n=%0d got %h want %h", n, bus.data_rdata, mem_val(prev_addr)); end
      end
      n_checks++; if (bus.inst_rvalid === 1'b1 && bus.data_rvalid === 1'b1) begin n_fail++; $display("FAIL rnd_both_rvalid n=%0d got 11 want at most one", n); end
      denied    = (i_pend && !exp_ir) ? denied + 1 : 0;
      prev_rd   = exp_ir || (exp_dr && d_wen == '0);
      prev_own  = exp_ir ? OWN_INST : OWN_DATA;
      prev_addr = exp_ir ? i_addr : d_addr;
      if (exp_ir) i_pend = 0;
      if (exp_dr) d_pend = 0;
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_contention();
    test_store();
    test_flush();
    test_interleave();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Fixed-priority arbiter with starvation guard that shares one single-port, synchronous-read instruction/data SRAM between the IF stage (instruction fetch) and the MEM stage (loads/stores). It sits between the two pipeline stages and the SRAM macro, issues at most one SRAM access per cycle, and routes the read data returned one cycle later to its owner. Data accesses win by default; a fetch denied for STARVE_MAX consecutive cycles is forced through.

## Interface
- ADDR_W, 32, address width of both requesters and SRAM
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive denied fetch cycles after which fetch takes priority (>=1)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- inst_req  in  1  IF requests a fetch; held with inst_addr stable until inst_ready
- inst_addr  in  ADDR_W  fetch address
- inst_cancel  in  1  IF flush (branch taken); drops a fetch response due this cycle
- inst_ready  out  1  fetch granted this cycle
- inst_rvalid  out  1  inst_rdata valid
- inst_rdata  out  DATA_W  fetched word
- data_req  in  1  MEM requests an access; held stable until data_ready
- data_wen  in  DATA_W/8  byte write enables; 0 = read
- data_addr  in  ADDR_W  access address
- data_wdata  in  DATA_W  store data
- data_ready  out  1  data access granted this cycle
- data_rvalid  out  1  data_rdata valid (reads only)
- data_rdata  out  DATA_W  loaded word
- sram_en  out  1  SRAM access enable
- sram_wen  out  DATA_W/8  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read with sram_en=1

## Operation
- Grant (combinational): starved = (starve_cnt == STARVE_MAX). inst_ready = inst_req & (~data_req | starved); data_ready = data_req & ~inst_ready.
- SRAM mux: sram_en = inst_ready | data_ready. Data grant drives data_addr/data_wen/data_wdata; fetch grant drives inst_addr, sram_wen=0, sram_wdata=0. No grant: sram_en=0, sram_wen=0, addr/wdata=0.
- Starvation counter: increments (saturating at STARVE_MAX) when inst_req & ~inst_ready; clears to 0 when inst_ready or ~inst_req. Width $clog2(STARVE_MAX+1).
- Response tracking: resp_vld_q <= granted read (fetch, or data with data_wen==0); resp_own_q <= INST/DATA of that grant.
- inst_rvalid = resp_vld_q & resp_own_q==INST & ~inst_cancel; data_rvalid = resp_vld_q & resp_own_q==DATA. Both rdata outputs = sram_rdata (unregistered).
- Writes: complete at grant; no rvalid produced.
- inst_cancel only masks a response due in that cycle; it does not block a new fetch grant in the same cycle.

## Timing
- Grant-to-rvalid latency: exactly 1 cycle; back-to-back grants every cycle, full throughput.
- Reset (reset=0, async): starve_cnt=0, resp_vld_q=0, resp_own_q=INST; thus inst_rvalid=data_rvalid=0 immediately. With inst_req=data_req=0, all sram_* outputs and readys are 0.
- Reset asserted mid-operation: pending response discarded; no rvalid after release.
- Both requesting, cnt<STARVE_MAX: data wins. At cnt==STARVE_MAX: fetch wins, data_ready=0, data retries next cycle (cnt clears).
- STARVE_MAX=1: arbitration alternates when both request continuously.
- Requester dropping req before ready is a protocol violation; behaviour undefined, no check required.

## Structure
- Package sram_arb_pkg: owner encoding (OWN_INST=1'b0, OWN_DATA=1'b1), default ADDR_W/DATA_W constants.
- Single module; starvation counter is small enough to stay inline, no sub-module.

## Test plan
- Fetch only: inst_req=1, inst_addr=0x1C000000 -> inst_ready=1 same cycle, sram_addr=0x1C000000, sram_wen=0; next cycle inst_rvalid=1, inst_rdata=sram_rdata.
- Contention, STARVE_MAX=4: both req held -> data_ready 4 cycles, fetch granted cycle 5, data regranted cycle 6.
- Store: data_req=1, data_wen=4'b0011, data_wdata=0xDEADBEEF, addr 0x100 -> sram_wen=4'b0011 for one cycle, no data_rvalid following.
- Branch flush: fetch granted, next cycle inst_cancel=1 -> inst_rvalid=0; a new fetch granted that cycle returns rvalid=1 the cycle after.
- Interleave: fetch granted cycle N, data read cycle N+1 -> inst_rvalid at N+1, data_rvalid at N+2, never both high.
- Async reset pulse between grant and response -> no rvalid; starve_cnt observed 0 after release.
